dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the pipeline's memory stage.
- Converts the MEM-stage data-memory access into a valid/ready bus transaction: word address, write data, 4-bit access pattern and write enable.
- Returns the raw 32-bit read word to the MEM stage; lane selection and sign extension remain in the datapath.
- Asserts stall to freeze the pipeline while a bus transaction is outstanding.

Parameters:
- XLEN, 32, data width.
- ADDR_SIZE, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- core_addr  in  ADDR_SIZE  MEM-stage byte address (ALU result).
- core_wdata  in  XLEN  store data, already lane-positioned.
- core_we  in  1  store request.
- core_re  in  1  load request.
- core_amp  in  4  byte-enable pattern for stores.
- core_rdata  out  XLEN  raw read word; valid while state==DONE.
- stall  out  1  pipeline freeze request.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_addr  out  ADDR_SIZE  word-aligned address, {addr[ADDR_SIZE-1:2],2'b00}.
- bus_wdata  out  XLEN  store data.
- bus_we  out  1  write enable.
- bus_be  out  4  byte enables; core_amp for stores, 4'b1111 for loads.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - A request is core_re | (core_we & core_amp!=0).
  - On a request: latch addr/wdata/be/we and go to REQ.
  - stall is combinational: 1 in IDLE while a request is present.
  - core_we with core_amp==0 is a no-op: no bus access, stall=0.
  - core_re and core_we both 1 is treated as a write.
- REQ:
  - bus_valid=1 and all bus_* outputs driven from latched registers, stable until handshake.
  - bus_valid=1 & bus_ready=1: write goes to DONE, read goes to WAIT.
  - stall=1.
- WAIT:
  - stall=1.
  - On bus_rvalid: capture bus_rdata into rdata_q and go to DONE.
  - bus_rvalid in the same cycle as the handshake is not accepted; it is only sampled in WAIT.
- DONE:
  - stall=0 and core_rdata=rdata_q.
  - Unconditionally go to IDLE. The pipeline advances at this edge, so the same access is never reissued.
- Latency with a zero-wait bus:
  - Load: 3 stall cycles, data presented in the 4th cycle.
  - Store: 2 stall cycles.
  - Each bus_ready or bus_rvalid wait cycle adds one stall cycle.
- bus_rvalid outside WAIT is ignored; this covers stale responses after reset.
- Reset values: state=IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata_q=0, core_rdata=0.
- stall is 0 during reset.
- Reset mid-transaction aborts immediately. No retry.
- Perf counter stall_cnt (32-bit, internal) increments every cycle stall=1 and wraps at 2^32.

Optional Feature:
- Macro: DMEM_WBUF_EN.
- Defined: adds a single-entry posted write buffer.
  - A store in IDLE with the buffer empty is captured into the buffer with stall=0.
  - The buffer drains through REQ (write), then goes to IDLE without DONE.
  - Any core request arriving while the buffer is full or draining stalls until the drain completes, then is processed normally. This preserves load-after-store ordering.
  - Reset empties the buffer and discards its contents.
- Undefined: stores follow the blocking path above and the buffer logic is absent.

Decomposition:
- FSM state encodings (DMB_IDLE, DMB_REQ, DMB_WAIT, DMB_DONE) and the full-word byte enable 4'b1111 go in xgriscv_defines.v.
- One natural sub-module, dmem_wbuf: the single-entry write buffer (valid flag, addr/data/be registers, drain handshake), instantiated only under DMEM_WBUF_EN.

Test Plan:
- Reset: hold reset=0 for 3 cycles while core_re=1 and bus_rvalid=1 -> stall=0, bus_valid=0, core_rdata=0 throughout.
- Zero-wait load:
  - Stimulus: core_re=1, core_addr=0x1006, bus_ready=1, bus_rvalid=1 with 0xA5A5_1234 in WAIT.
  - Response: bus_addr=0x1004, bus_be=4'b1111, stall high for exactly 3 cycles, core_rdata=0xA5A5_1234 in cycle 4.
- Store with backpressure:
  - Stimulus: core_we=1, core_amp=4'b0100, core_wdata=0x00AB_0000, bus_ready low for 2 cycles.
  - Response: bus_valid, bus_addr, bus_be and bus_wdata stable across the wait cycles, stall=4 cycles total, bus_we=1.
- Zero-pattern store: core_we=1, core_amp=0 -> no bus_valid, stall=0.
- Mid-transaction reset: assert reset=0 in WAIT, then send bus_rvalid=1 after release -> state IDLE, response ignored, no stall.
- DMEM_WBUF_EN:
  - Stimulus: store to 0x20 followed immediately by a load from 0x20, bus zero-wait.
  - Response: store has stall=0; load stalls until the buffered write's handshake completes; bus order is write then read.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
// Optional build macro: DMEM_WBUF_EN (single-entry posted write buffer).
package dmem_bus_bridge_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned BE_W      = 4;

  localparam logic [BE_W-1:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    DMB_IDLE = 2'd0,
    DMB_REQ  = 2'd1,
    DMB_WAIT = 2'd2,
    DMB_DONE = 2'd3
  } dmbState_e;

  // One bus request as presented on the valid/ready channel.
  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [XLEN-1:0]      wdata;
    logic [BE_W-1:0]      be;
    logic                 we;
  } dmbReq_t;

  // Clear the byte offset to form a word address.
  function automatic logic [ADDR_SIZE-1:0] wordAlign(input logic [ADDR_SIZE-1:0] a);
    return a & ~ADDR_SIZE'(3);
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Valid/ready data-memory bus between the bridge (master) and memory (slave).
interface dmem_bus_bridge_if;
  import dmem_bus_bridge_pkg::*;

  logic                 bus_valid;
  logic                 bus_ready;
  logic [ADDR_SIZE-1:0] bus_addr;
  logic [XLEN-1:0]      bus_wdata;
  logic                 bus_we;
  logic [BE_W-1:0]      bus_be;
  logic                 bus_rvalid;
  logic [XLEN-1:0]      bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_wdata, bus_we, bus_be,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata, bus_we, bus_be,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/dmem_bus_bridge_wbuf.sv
// Single-entry posted write buffer; holds one store until the bridge drains it.
module dmem_wbuf
  import dmem_bus_bridge_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  dmbReq_t pushReq,
  input  logic    pop,
  output logic    valid,
  output dmbReq_t entry
);

  // Capture a store on push; release the slot when the drain is launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (push) begin
      valid <= 1'b1;
      entry <= pushReq;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage to valid/ready bus bridge; stalls the pipeline while an access is outstanding.
// Optional build macro: DMEM_WBUF_EN adds a posted write buffer (dmem_wbuf).
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] core_addr,
  input  logic [XLEN-1:0]      core_wdata,
  input  logic                 core_we,
  input  logic                 core_re,
  input  logic [BE_W-1:0]      core_amp,
  output logic [XLEN-1:0]      core_rdata,
  output logic                 stall,
  dmem_bus_bridge_if.master    bus
);

  dmbState_e       stateQ, stateNext;
  dmbReq_t         reqQ, reqNext, newReq;
  logic [XLEN-1:0] rdataQ, rdataNext;
  logic            busValidQ;
  logic            stallRaw;
  logic [31:0]     stallCnt;
  logic            coreWrite, coreReq;

  // A store with an empty pattern is not an access; a store wins over a load.
  assign coreWrite = core_we & (core_amp != '0);
  assign coreReq   = core_re | coreWrite;

  assign newReq.addr  = wordAlign(core_addr);
  assign newReq.wdata = core_wdata;
  assign newReq.be    = coreWrite ? core_amp : BE_FULL;
  assign newReq.we    = coreWrite;

`ifdef DMEM_WBUF_EN
  logic    drainQ, drainNext;
  logic    wbufPush, wbufPop, wbufValid;
  dmbReq_t wbufEntry;

  dmem_wbuf u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push    (wbufPush),
    .pushReq (newReq),
    .pop     (wbufPop),
    .valid   (wbufValid),
    .entry   (wbufEntry)
  );

  // Marks a REQ that is draining the write buffer rather than serving the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drainQ <= 1'b0;
    else        drainQ <= drainNext;
  end
`endif

  // State, latched request, read data, bus valid and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= DMB_IDLE;
      reqQ      <= '0;
      rdataQ    <= '0;
      busValidQ <= 1'b0;
      stallCnt  <= '0;
    end else begin
      stateQ    <= stateNext;
      reqQ      <= reqNext;
      rdataQ    <= rdataNext;
      busValidQ <= (stateNext == DMB_REQ);
      if (stall) stallCnt <= stallCnt + 32'd1;
    end
  end

  // Next-state, request latch and stall decode.
  always_comb begin
    stateNext = stateQ;
    reqNext   = reqQ;
    rdataNext = rdataQ;
    stallRaw  = 1'b0;
`ifdef DMEM_WBUF_EN
    drainNext = drainQ;
    wbufPush  = 1'b0;
    wbufPop   = 1'b0;
`endif
    case (stateQ)
      DMB_IDLE: begin
`ifdef DMEM_WBUF_EN
        if (wbufValid) begin
          // Drain first so a following load observes the buffered store.
          stallRaw  = coreReq;
          reqNext   = wbufEntry;
          wbufPop   = 1'b1;
          drainNext = 1'b1;
          stateNext = DMB_REQ;
        end else if (coreWrite) begin
          wbufPush = 1'b1;
        end else if (core_re) begin
          stallRaw  = 1'b1;
          reqNext   = newReq;
          drainNext = 1'b0;
          stateNext = DMB_REQ;
        end
`else
        if (coreReq) begin
          stallRaw  = 1'b1;
          reqNext   = newReq;
          stateNext = DMB_REQ;
        end
`endif
      end
      DMB_REQ: begin
`ifdef DMEM_WBUF_EN
        stallRaw = drainQ ? coreReq : 1'b1;
        if (bus.bus_ready) begin
          drainNext = 1'b0;
          if (drainQ)       stateNext = DMB_IDLE;
          else if (reqQ.we) stateNext = DMB_DONE;
          else              stateNext = DMB_WAIT;
        end
`else
        stallRaw = 1'b1;
        if (bus.bus_ready) stateNext = reqQ.we ? DMB_DONE : DMB_WAIT;
`endif
      end
      DMB_WAIT: begin
        stallRaw = 1'b1;
        if (bus.bus_rvalid) begin
          rdataNext = bus.bus_rdata;
          stateNext = DMB_DONE;
        end
      end
      DMB_DONE: begin
        stateNext = DMB_IDLE;
      end
      default: stateNext = DMB_IDLE;
    endcase
  end

  assign stall          = stallRaw & reset;
  assign core_rdata     = rdataQ;
  assign bus.bus_valid  = busValidQ;
  assign bus.bus_addr   = reqQ.addr;
  assign bus.bus_wdata  = reqQ.wdata;
  assign bus.bus_we     = reqQ.we;
  assign bus.bus_be     = reqQ.be;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge; optional DMEM_WBUF_EN section.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADDR_SIZE-1:0] core_addr;
  logic [XLEN-1:0]      core_wdata;
  logic                 core_we;
  logic                 core_re;
  logic [BE_W-1:0]      core_amp;
  logic [XLEN-1:0]      core_rdata;
  logic                 stall;

  int nChecks = 0;
  int nFails  = 0;
  int stallTotal = 0;
  int snap;

  dmem_bus_bridge_if busIf();

  dmem_bus_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_re    (core_re),
    .core_amp   (core_amp),
    .core_rdata (core_rdata),
    .stall      (stall),
    .bus        (busIf.master)
  );

  always #5 clk = ~clk;

  // Stall cycles seen by the pipeline, sampled mid-cycle.
  always @(negedge clk) if (stall === 1'b1) stallTotal++;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b1; core_amp = '0;
    busIf.bus_ready = 1'b0; busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'hCAFE_F00D;

    // Reset held with a pending load and a stale response.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("rst_stall", 64'(stall), 64'(0));
      checkEq("rst_valid", 64'(busIf.bus_valid), 64'(0));
      checkEq("rst_rdata", 64'(core_rdata), 64'(0));
    end
    checkEq("rst_addr", 64'(busIf.bus_addr), 64'(0));
    checkEq("rst_be", 64'(busIf.bus_be), 64'(0));
    reset = 1'b1; core_re = 1'b0; busIf.bus_rvalid = 1'b0;
    tick();

    // Zero-wait load; response during REQ must be ignored.
    snap = stallTotal;
    core_addr = 32'h0000_1006; core_re = 1'b1;
    busIf.bus_ready = 1'b1; busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'hDEAD_BEEF;
    #1 checkEq("ld_stall_idle", 64'(stall), 64'(1));
    tick();
    checkEq("ld_valid", 64'(busIf.bus_valid), 64'(1));
    checkEq("ld_addr", 64'(busIf.bus_addr), 64'h1004);
    checkEq("ld_be", 64'(busIf.bus_be), 64'hF);
    checkEq("ld_we", 64'(busIf.bus_we), 64'(0));
    tick();
    checkEq("ld_stall_wait", 64'(stall), 64'(1));
    checkEq("ld_valid_wait", 64'(busIf.bus_valid), 64'(0));
    busIf.bus_rdata = 32'hA5A5_1234;
    tick();
    checkEq("ld_stall_done", 64'(stall), 64'(0));
    checkEq("ld_rdata", 64'(core_rdata), 64'hA5A5_1234);
    core_re = 1'b0; busIf.bus_rvalid = 1'b0;
    tick();
    checkEq("ld_stall_cnt", 64'(stallTotal - snap), 64'(3));

`ifdef DMEM_WBUF_EN
    // Posted store followed by a load to the same word.
    core_we = 1'b1; core_amp = 4'b1111; core_addr = 32'h20; core_wdata = 32'h1122_3344;
    busIf.bus_ready = 1'b1;
    #1 checkEq("wb_st_stall", 64'(stall), 64'(0));
    tick();
    checkEq("wb_buf_valid", 64'(busIf.bus_valid), 64'(0));
    core_we = 1'b0; core_amp = '0; core_re = 1'b1;
    #1 checkEq("wb_ld_stall", 64'(stall), 64'(1));
    tick();
    checkEq("wb_drain_valid", 64'(busIf.bus_valid), 64'(1));
    checkEq("wb_drain_we", 64'(busIf.bus_we), 64'(1));
    checkEq("wb_drain_addr", 64'(busIf.bus_addr), 64'h20);
    checkEq("wb_drain_wdata", 64'(busIf.bus_wdata), 64'h1122_3344);
    checkEq("wb_drain_stall", 64'(stall), 64'(1));
    tick();
    checkEq("wb_gap_valid", 64'(busIf.bus_valid), 64'(0));
    checkEq("wb_gap_stall", 64'(stall), 64'(1));
    tick();
    checkEq("wb_rd_valid", 64'(busIf.bus_valid), 64'(1));
    checkEq("wb_rd_we", 64'(busIf.bus_we), 64'(0));
    busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'h0BAD_F00D;
    tick();
    tick();
    checkEq("wb_rd_data", 64'(core_rdata), 64'h0BAD_F00D);
    checkEq("wb_rd_stall", 64'(stall), 64'(0));
    core_re = 1'b0; busIf.bus_rvalid = 1'b0;
    tick();
`else
    // Byte store with two cycles of backpressure.
    snap = stallTotal;
    core_we = 1'b1; core_amp = 4'b0100; core_wdata = 32'h00AB_0000; core_addr = 32'h2003;
    busIf.bus_ready = 1'b0;
    #1 checkEq("st_stall_idle", 64'(stall), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("st_valid", 64'(busIf.bus_valid), 64'(1));
      checkEq("st_addr", 64'(busIf.bus_addr), 64'h2000);
      checkEq("st_be", 64'(busIf.bus_be), 64'h4);
      checkEq("st_wdata", 64'(busIf.bus_wdata), 64'h00AB_0000);
      checkEq("st_we", 64'(busIf.bus_we), 64'(1));
      if (i == 2) busIf.bus_ready = 1'b1;
    end
    tick();
    checkEq("st_stall_done", 64'(stall), 64'(0));
    checkEq("st_valid_done", 64'(busIf.bus_valid), 64'(0));
    core_we = 1'b0; core_amp = '0;
    tick();
    checkEq("st_stall_cnt", 64'(stallTotal - snap), 64'(4));

    // Load and store together is a store.
    core_re = 1'b1; core_we = 1'b1; core_amp = 4'b0011; core_wdata = 32'h0000_BEEF;
    core_addr = 32'h3000;
    tick();
    checkEq("rw_we", 64'(busIf.bus_we), 64'(1));
    checkEq("rw_be", 64'(busIf.bus_be), 64'h3);
    tick();
    checkEq("rw_stall_done", 64'(stall), 64'(0));
    core_re = 1'b0; core_we = 1'b0; core_amp = '0;
    tick();
`endif

    // Store with an empty pattern is a no-op.
    core_we = 1'b1; core_amp = 4'b0000; core_addr = 32'h40;
    #1 checkEq("z_stall", 64'(stall), 64'(0));
    tick();
    checkEq("z_valid", 64'(busIf.bus_valid), 64'(0));
    checkEq("z_stall2", 64'(stall), 64'(0));
    core_we = 1'b0;
    tick();

    // Reset while waiting for read data, then a stale response.
    core_re = 1'b1; core_addr = 32'h50; busIf.bus_ready = 1'b1; busIf.bus_rvalid = 1'b0;
    tick();
    tick();
    checkEq("mr_stall_wait", 64'(stall), 64'(1));
    reset = 1'b0; core_re = 1'b0;
    #1 checkEq("mr_stall_rst", 64'(stall), 64'(0));
    checkEq("mr_valid_rst", 64'(busIf.bus_valid), 64'(0));
    tick();
    tick();
    reset = 1'b1; busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'h1234_5678;
    tick();
    checkEq("mr_stall", 64'(stall), 64'(0));
    checkEq("mr_valid", 64'(busIf.bus_valid), 64'(0));
    checkEq("mr_rdata", 64'(core_rdata), 64'(0));
    tick();
    checkEq("mr_rdata2", 64'(core_rdata), 64'(0));
    checkEq("mr_stall2", 64'(stall), 64'(0));
    busIf.bus_rvalid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
